// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and ALU control bundle between the sequencer and its surroundings.
// master: the sequencer; slave: fetch/datapath side.
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        alu_zero;
  logic [3:0]  cu_aluOp;
  logic [4:0]  shamt;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        branch_taken;
  logic        illegal;
  logic        busy;
  logic [31:0] instr_count;

  modport master (
    input  instr_valid, instr, alu_zero,
    output instr_ready, cu_aluOp, shamt, rs_addr, rt_addr, rd_addr,
           reg_write, branch_taken, illegal, busy, instr_count
  );

  modport slave (
    output instr_valid, instr, alu_zero,
    input  instr_ready, cu_aluOp, shamt, rs_addr, rt_addr, rd_addr,
           reg_write, branch_taken, illegal, busy, instr_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle DECODE/EXEC/WB sequencer issuing cu_aluOp/shamt/addresses to the datapath ALU.
// Optional retired-instruction counter enabled by defining ALU_SEQ_INSTR_COUNT_EN.
module alu_op_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter logic [5:0]  BRANCH_OPCODE = 6'h10
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic [4:0] rs_q, rt_q, rd_q, shamt_q;
  logic [3:0] cnt_q, cnt_d;

  logic       accept;
  logic       active;
  logic       is_nop, is_branch, is_alu, is_illegal, is_muldiv;
  logic [3:0] alu_op;

  assign accept = (state_q == StIdle) && bus.instr_valid;
  assign active = (state_q != StIdle);

  // Decode is purely a function of the captured opcode, so it stays stable until WB.
  always_comb begin
    is_nop     = (opcode_q == 6'h00);
    is_branch  = (opcode_q == BRANCH_OPCODE) && !is_nop;
    is_alu     = !is_nop && !is_branch && (opcode_q[5:4] == 2'b00);
    is_illegal = !is_nop && !is_branch && !is_alu;
    alu_op     = 4'b0000;
    if (is_branch) begin
      alu_op = 4'b0010;
    end else if (is_alu) begin
      alu_op = opcode_q[3:0];
    end
    is_muldiv  = is_alu && (alu_op inside {4'hC, 4'hD, 4'hE});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      shamt_q  <= '0;
    end else if (accept) begin
      opcode_q <= bus.instr[31:26];
      rs_q     <= bus.instr[25:21];
      rt_q     <= bus.instr[20:16];
      rd_q     <= bus.instr[15:11];
      shamt_q  <= bus.instr[10:6];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_nop) begin
          state_d = StWb;
        end else if (is_illegal) begin
          state_d = StIdle;
        end else begin
          state_d = StExec;
          // Counter holds remaining EXEC cycles after the current one.
          cnt_d   = is_muldiv ? 4'(MULDIV_CYCLES - 1) : 4'd0;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.instr_ready  = !active;
  assign bus.busy         = active;
  assign bus.cu_aluOp     = active ? alu_op : 4'b0000;
  assign bus.shamt        = active ? shamt_q : 5'd0;
  assign bus.rs_addr      = active ? rs_q : 5'd0;
  assign bus.rt_addr      = active ? rt_q : 5'd0;
  assign bus.rd_addr      = active ? rd_q : 5'd0;
  assign bus.illegal      = (state_q == StDecode) && is_illegal;
  assign bus.reg_write    = (state_q == StWb) && is_alu && (rd_q != 5'd0);
  assign bus.branch_taken = (state_q == StWb) && is_branch && bus.alu_zero;

`ifdef ALU_SEQ_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_q == StWb) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = '0;
`endif

  logic unused_instr_low;
  assign unused_instr_low = ^bus.instr[5:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table plus randomized instruction stream.
module tb_alu_op_sequencer;

  localparam int unsigned M = 4;

`ifdef ALU_SEQ_INSTR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [3:0] aluop;
    logic [4:0] shamt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       bt;
    logic       ill;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] w;
    logic        zero;
    int          rst_at;
    int          exp_busy;
    int          exp_rw;
    int          exp_bt;
    int          exp_ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_count = '0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MULDIV_CYCLES(M),
    .BRANCH_OPCODE(6'h10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'h2A};
  endfunction

  function automatic out_t actual();
    out_t a;
    a.ready = bus.instr_ready;
    a.busy  = bus.busy;
    a.aluop = bus.cu_aluOp;
    a.shamt = bus.shamt;
    a.rs    = bus.rs_addr;
    a.rt    = bus.rt_addr;
    a.rd    = bus.rd_addr;
    a.rw    = bus.reg_write;
    a.bt    = bus.branch_taken;
    a.ill   = bus.illegal;
    return a;
  endfunction

  function automatic out_t idle_out();
    out_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  task automatic chk_out(input string name, input out_t exp);
    out_t act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (ready busy op sh rs rt rd rw bt ill)", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one instruction and check every cycle against the architectural rules.
  task automatic run_instr(input string name, input logic [31:0] w, input logic zero,
                           input int rst_at, input logic hold, input logic [31:0] next_w,
                           output int n_busy, output int n_rw, output int n_bt,
                           output int n_ill);
    logic [5:0] op = w[31:26];
    logic       nop = (op == 6'h00);
    logic       br = (op == 6'h10);
    logic       alu = (op >= 6'h01) && (op <= 6'h0F);
    logic       ill = !(nop || br || alu);
    logic       md = alu && (op[3:0] >= 4'hC) && (op[3:0] <= 4'hE);
    logic       writes = alu && (w[15:11] != 5'd0);
    int         dur = ill ? 1 : nop ? 2 : md ? 2 + int'(M) : 3;
    bit         aborted = 1'b0;
    int         n = 0;
    out_t       e;
    n_busy = 0; n_rw = 0; n_bt = 0; n_ill = 0;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    bus.alu_zero    = zero;
    #1;
    while (!bus.instr_ready && n < 50) begin
      tick();
      n++;
    end
    chk_int({name, " ready"}, longint'(bus.instr_ready), 1);
    tick();
    bus.instr_valid = hold;
    bus.instr       = hold ? next_w : $urandom;
    #1;
    for (int c = 1; c <= dur; c++) begin
      e       = '0;
      e.busy  = 1'b1;
      e.aluop = br ? 4'b0010 : alu ? op[3:0] : 4'b0000;
      e.shamt = w[10:6];
      e.rs    = w[25:21];
      e.rt    = w[20:16];
      e.rd    = w[15:11];
      e.rw    = (c == dur) && writes;
      e.bt    = (c == dur) && br && zero;
      e.ill   = (c == 1) && ill;
      chk_out($sformatf("%s cyc%0d", name, c), e);
      n_busy += int'(bus.busy);
      n_rw   += int'(bus.reg_write);
      n_bt   += int'(bus.branch_taken);
      n_ill  += int'(bus.illegal);
      if (c == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      tick();
    end
    if (aborted) begin
      exp_count = '0;
    end else if (!ill && CntEn) begin
      exp_count = exp_count + 32'd1;
    end
    chk_out({name, " idle"}, idle_out());
    n_rw += int'(bus.reg_write);
    chk_int({name, " count"}, longint'(bus.instr_count), longint'(exp_count));
  endtask

  vec_t tbl[$];

  initial begin
    int nb, nr, nt, ni;
    logic [31:0] cur, nxt;

    tbl.push_back('{"add",     mk(6'h01, 5'd3, 5'd4, 5'd5, 5'd0),   1'b0, 0, 3, 1, 0, 0});
    tbl.push_back('{"mul",     mk(6'h0C, 5'd1, 5'd2, 5'd6, 5'd0),   1'b0, 0, 6, 1, 0, 0});
    tbl.push_back('{"div_r0",  mk(6'h0D, 5'd1, 5'd2, 5'd0, 5'd0),   1'b0, 0, 6, 0, 0, 0});
    tbl.push_back('{"br_eq",   mk(6'h10, 5'd7, 5'd7, 5'd9, 5'd0),   1'b1, 0, 3, 0, 1, 0});
    tbl.push_back('{"br_ne",   mk(6'h10, 5'd7, 5'd8, 5'd9, 5'd0),   1'b0, 0, 3, 0, 0, 0});
    tbl.push_back('{"ill3f",   mk(6'h3F, 5'd1, 5'd2, 5'd3, 5'd4),   1'b0, 0, 1, 0, 0, 1});
    tbl.push_back('{"nop",     mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0),   1'b0, 0, 2, 0, 0, 0});
    tbl.push_back('{"rem_rst", mk(6'h0E, 5'd1, 5'd2, 5'd10, 5'd0),  1'b0, 3, 3, 0, 0, 0});
    tbl.push_back('{"shift",   mk(6'h09, 5'd11, 5'd12, 5'd8, 5'd7), 1'b0, 0, 3, 1, 0, 0});
    tbl.push_back('{"ill20",   mk(6'h20, 5'd1, 5'd2, 5'd3, 5'd0),   1'b0, 0, 1, 0, 0, 1});
    tbl.push_back('{"or_r31",  mk(6'h0F, 5'd1, 5'd2, 5'd31, 5'd3),  1'b1, 0, 3, 1, 0, 0});

    // Reset with instr_valid high: nothing may be accepted.
    bus.instr       = mk(6'h01, 5'd1, 5'd2, 5'd3, 5'd0);
    bus.instr_valid = 1'b1;
    bus.alu_zero    = 1'b0;
    rst             = 1'b1;
    tick();
    chk_out("reset1", idle_out());
    tick();
    chk_out("reset2", idle_out());
    chk_int("reset count", longint'(bus.instr_count), 0);
    bus.instr_valid = 1'b0;
    rst             = 1'b0;
    tick();
    chk_out("post_reset", idle_out());

    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].w, tbl[i].zero, tbl[i].rst_at, 1'b0, '0, nb, nr, nt, ni);
      chk_int({tbl[i].name, " summary"},
              longint'({nb[7:0], nr[7:0], nt[7:0], ni[7:0]}),
              longint'({tbl[i].exp_busy[7:0], tbl[i].exp_rw[7:0],
                        tbl[i].exp_bt[7:0], tbl[i].exp_ill[7:0]}));
    end

    // Backpressure: next word held valid through the whole flight of the previous one.
    run_instr("bp_a", mk(6'h0C, 5'd2, 5'd3, 5'd4, 5'd0), 1'b0, 0, 1'b1,
              mk(6'h03, 5'd5, 5'd6, 5'd7, 5'd1), nb, nr, nt, ni);
    run_instr("bp_b", mk(6'h03, 5'd5, 5'd6, 5'd7, 5'd1), 1'b0, 0, 1'b0, '0, nb, nr, nt, ni);
    chk_int("bp_b rw", longint'(nr), 1);

    cur = '0;
    for (int k = 0; k < 200; k++) begin
      int   r = int'($urandom_range(0, 9));
      logic [5:0] op;
      int   ra;
      if (r == 0)      op = 6'h00;
      else if (r == 1) op = 6'h10;
      else if (r <= 3) op = 6'(12 + $urandom_range(0, 2));
      else if (r <= 7) op = 6'($urandom_range(1, 15));
      else             op = 6'($urandom_range(17, 63));
      nxt = {op, 26'($urandom)};
      if (k == 0) cur = nxt;
      ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
      begin
        logic [31:0] upcoming = {6'($urandom_range(0, 15)), 26'($urandom)};
        logic        hold = ($urandom_range(0, 3) == 0) && (ra == 0);
        run_instr($sformatf("rnd%0d", k), cur, 1'($urandom), ra, hold, upcoming,
                  nb, nr, nt, ni);
        cur = hold ? upcoming : nxt;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control-unit slice that issues operations to the datapath ALU; the initiating end of the cu_aluOp/shamt/zero interface.
- Accepts one instruction word per valid/ready handshake and decodes it into cu_aluOp, shamt and register addresses.
- Sequences DECODE/EXEC/WB, stalls for multiply/divide/remainder, and pulses reg_write at writeback.

Parameters:
- MULDIV_CYCLES, 4, EXEC residency in cycles for aluOp 1100/1101/1110; legal range 1..15.
- BRANCH_OPCODE, 6'h10, opcode of compare-and-branch (ALU subtract, no writeback).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] ignored
- instr_ready  out  1  sequencer can accept an instruction
- alu_zero  in  1  zero flag from ALU
- cu_aluOp  out  4  ALU operation select
- shamt  out  5  shift amount to ALU
- rs_addr  out  5  register-file read port 1 address
- rt_addr  out  5  register-file read port 2 address
- rd_addr  out  5  writeback address
- reg_write  out  1  one-cycle register-file write strobe
- branch_taken  out  1  one-cycle pulse: branch compare equal
- illegal  out  1  one-cycle pulse: undefined opcode
- busy  out  1  high in any state other than IDLE
- instr_count  out  32  retired-instruction counter (optional feature)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, except instr_ready=1. State=IDLE.
- States: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, register all instr fields and go to DECODE. instr is not sampled otherwise.
- DECODE (1 cycle): instr_ready=0; drive cu_aluOp, shamt, rs_addr, rt_addr, rd_addr from the captured word.
  - Opcode 0x00: NOP; cu_aluOp=0000; go to WB with no write.
  - Opcodes 0x01..0x0F: cu_aluOp=opcode[3:0].
  - BRANCH_OPCODE: cu_aluOp=0010.
  - Any other opcode: pulse illegal, drive cu_aluOp=0000, return to IDLE; no reg_write.
- EXEC:
  - Default residency is 1 cycle.
  - cu_aluOp in {1100,1101,1110}: residency is exactly MULDIV_CYCLES cycles, counted by a 4-bit down-counter loaded on DECODE exit.
  - Then go to WB.
- WB (1 cycle):
  - ALU opcodes: reg_write=1 unless rd_addr==0 (r0 is never written).
  - BRANCH_OPCODE: reg_write=0; branch_taken=alu_zero sampled this cycle.
  - Then IDLE.
- cu_aluOp, shamt and all addresses:
  - Hold stable from DECODE through WB.
  - Return to 0 in IDLE.
- Latency, accept to reg_write: 3 cycles for single-cycle ops; 2+MULDIV_CYCLES for mul/div/rem.
- Throughput: next instruction is accepted in the cycle after WB. No overlap.
- Backpressure: instr_valid held high while busy is ignored; the word is taken when instr_ready returns.
- rst asserted in any state: next edge forces IDLE and all outputs to reset values. The in-flight instruction is dropped with no reg_write and no branch_taken. The counter reloads on the next accept.
- rst and instr_valid asserted together: reset wins; nothing is accepted.
- Divide/remainder by zero is not detected here; the result is whatever the ALU produces.

Optional Feature:
- Macro ALU_SEQ_INSTR_COUNT_EN.
- Defined:
  - instr_count increments by 1 in each WB cycle, including NOP and branch; illegal opcodes do not count.
  - Wraps 32'hFFFFFFFF -> 0.
  - Cleared by rst.
- Undefined: instr_count is constant 0 and no counter flop exists. The port is present in both builds.

Test Plan:
- Reset: rst high 2 cycles with instr_valid=1 -> instr_ready=1, busy=0, reg_write=0, cu_aluOp=0 and no accept.
- Add: instr opcode 0x01, rs=3, rt=4, rd=5 -> cu_aluOp=0001 with rs_addr=3 and rt_addr=4 from DECODE through WB; reg_write=1 with rd_addr=5 exactly 3 cycles after accept; instr_ready low for 3 cycles.
- Multiply, MULDIV_CYCLES=4: opcode 0x0C -> cu_aluOp=1100 held 6 cycles; reg_write pulses 6 cycles after accept. Repeat with opcode 0x0D and rd=0 -> no reg_write.
- Branch: opcode 0x10 with alu_zero=1 in WB -> branch_taken pulses once, reg_write=0. Repeat with alu_zero=0 -> no pulse.
- Illegal opcode 0x3F -> illegal pulses in DECODE cycle, back to IDLE next cycle, no reg_write; with macro defined, instr_count unchanged.
- Mid-operation reset: accept opcode 0x0E, assert rst on 2nd EXEC cycle -> IDLE next edge, no reg_write ever. Afterwards a shift opcode 0x09 with shamt=7 completes normally with shamt=7.
